// File: rtl/cache_definition.sv
// Shared types and constants for the CPU <-> sa_cache interface.
//   cpu_to_cache_type : request from the CPU side to the cache (data, addr, rw, valid)
//   cache_to_cpu_type : response from the cache (data, ready, stopped)
//   cpu_req_type      : one queued CPU request (FIFO entry of cpu_req_buffer)
package cache_definition;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;

    // rw: 1 = write, 0 = read
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic              valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
        logic              stopped;
    } cache_to_cpu_type;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cpu_req_type;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and data (ignored when full)
//   pop             : read request (ignored when empty)
//   rdata           : current head entry (valid when !empty)
//   full, empty     : occupancy flags from registered count
//   count           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: contents are never observed while empty.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cpu_req_buffer.sv
// In-order request buffer between the CPU and sa_cache.
// Queues CPU requests, issues them to the cache (holding while stopped), limits
// the number of unanswered reads, returns read data and flags stray responses.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/rw/addr/data, req_ready : CPU request channel (rw 1 = write)
//   cpu_to_cache    : request to the cache, driven from the FIFO head
//   cache_to_cpu    : cache response (data, ready, stopped)
//   rsp_valid/data  : registered read response to the CPU
//   rd_outstanding  : reads issued and not yet answered
//   proto_err       : sticky flag, ready seen with no read outstanding
module cpu_req_buffer
    import cache_definition::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MAX_RD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_rw,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_data,
    output logic                    req_ready,
    output cpu_to_cache_type        cpu_to_cache,
    input  cache_to_cpu_type        cache_to_cpu,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [$clog2(MAX_RD):0] rd_outstanding,
    output logic                    proto_err
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned RdW  = $clog2(MAX_RD) + 1;

    cpu_req_type       wr_entry, head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;

    logic [RdW-1:0]    rd_cnt_q, rd_cnt_d;
    logic              rd_inc, rd_dec, rd_room, issue_valid;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              proto_err_q;

    assign wr_entry = '{rw: req_rw, addr: req_addr, data: req_data};

    assign req_ready = (fifo_count != CntW'(DEPTH));
    assign fifo_push = req_valid && !fifo_full;

    sync_fifo #(
        .WIDTH ($bits(cpu_req_type)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Writes never wait for read credit; only a read head is throttled.
    assign rd_room     = (rd_cnt_q < RdW'(MAX_RD));
    assign issue_valid = !fifo_empty && (head.rw || rd_room);
    assign fifo_pop    = issue_valid && !cache_to_cpu.stopped;

    always_comb begin
        cpu_to_cache = '0;
        if (!fifo_empty) begin
            cpu_to_cache.data = head.data;
            cpu_to_cache.addr = head.addr;
            cpu_to_cache.rw   = head.rw;
        end
        cpu_to_cache.valid = issue_valid;
    end

    assign rd_inc = fifo_pop && !head.rw;
    assign rd_dec = cache_to_cpu.ready && (rd_cnt_q != '0);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        case ({rd_inc, rd_dec})
            2'b10:   rd_cnt_d = rd_cnt_q + RdW'(1);
            2'b01:   rd_cnt_d = rd_cnt_q - RdW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            rsp_valid_q <= cache_to_cpu.ready;
            // Unsolicited data is still forwarded; the error flag records it.
            if (cache_to_cpu.ready) rsp_data_q <= cache_to_cpu.data;
            if (cache_to_cpu.ready && (rd_cnt_q == '0)) proto_err_q <= 1'b1;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rd_outstanding = rd_cnt_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_cpu_req_buffer.sv
// Scoreboard bench for cpu_req_buffer: a queue-level reference model tracks
// accepted requests, read credit and expected responses; a negedge monitor
// compares the DUT against it every cycle.
module tb_cpu_req_buffer;
    import cache_definition::*;

    localparam int DEPTH  = 4;
    localparam int MAX_RD = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    req_rw = 1'b0;
    logic [ADDR_W-1:0]       req_addr = '0;
    logic [DATA_W-1:0]       req_data = '0;
    logic                    req_ready;
    cpu_to_cache_type        cpu_to_cache;
    cache_to_cpu_type        cache_to_cpu = '0;
    logic                    rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [$clog2(MAX_RD):0] rd_outstanding;
    logic                    proto_err;

    int checks = 0;
    int errors = 0;

    cpu_req_buffer #(
        .DEPTH  (DEPTH),
        .MAX_RD (MAX_RD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .cpu_to_cache   (cpu_to_cache),
        .cache_to_cpu   (cache_to_cpu),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rd_outstanding (rd_outstanding),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data the cache model returns for a read of address a.
    function automatic logic [31:0] rd_value(input logic [19:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], 4'h0, a[19:8]};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic        rw;
        logic [19:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        mq[$];          // requests accepted, not yet issued, in order
    logic [31:0] exp_rsp[$];     // expected read data, in request order
    int          mout = 0;       // reads issued and not answered
    bit          merr = 0;
    bit          m_rsp_v = 0;
    bit          m_unsol = 0;
    logic [31:0] m_last = '0;

    function automatic bit model_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].rw || (mout < MAX_RD);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_rsp.delete();
            mout    = 0;
            merr    = 0;
            m_rsp_v = 0;
            m_unsol = 0;
            m_last  = '0;
        end else begin
            bit   acc, hs, inc, dec;
            req_t r;
            acc     = req_valid && (mq.size() < DEPTH);
            hs      = model_valid() && !cache_to_cpu.stopped;
            inc     = hs && !mq[0].rw;
            dec     = cache_to_cpu.ready && (mout > 0);
            m_rsp_v = cache_to_cpu.ready;
            m_unsol = cache_to_cpu.ready && (mout == 0);
            if (m_unsol) merr = 1;
            if (cache_to_cpu.ready) m_last = cache_to_cpu.data;
            mout = mout + int'(inc) - int'(dec);
            if (hs) void'(mq.pop_front());
            if (acc) begin
                r.rw   = req_rw;
                r.addr = req_addr;
                r.data = req_data;
                mq.push_back(r);
                if (!req_rw) exp_rsp.push_back(rd_value(req_addr));
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            check("issue_valid", 32'(cpu_to_cache.valid), 32'(model_valid()));
            if (mq.size() > 0) begin
                check("issue_addr", 32'(cpu_to_cache.addr), 32'(mq[0].addr));
                check("issue_rw", 32'(cpu_to_cache.rw), 32'(mq[0].rw));
                if (mq[0].rw) check("issue_data", cpu_to_cache.data, mq[0].data);
            end else begin
                check("idle_fields", 32'({cpu_to_cache.rw, cpu_to_cache.addr}), 32'h0);
                check("idle_data", cpu_to_cache.data, 32'h0);
            end
            check("rd_outstanding", 32'(rd_outstanding), 32'(mout));
            check("proto_err", 32'(proto_err), 32'(merr));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
            check("rsp_data", rsp_data, m_last);
            if (rsp_valid && !m_unsol) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_order: got 0x%08h expected no response", rsp_data);
                end else begin
                    check("rsp_order", rsp_data, exp_rsp.pop_front());
                end
            end
        end
    end

    // ---------------- cache model ----------------
    typedef struct {
        logic [19:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    cache_lat = 0;        // 0 selects a random latency of 1..4

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        pend_t p;
        @(negedge clk);
        if (rst) begin
            pend.delete();
        end else if (cpu_to_cache.valid && !cache_to_cpu.stopped && !cpu_to_cache.rw) begin
            p.addr = cpu_to_cache.addr;
            p.due  = cyc + ((cache_lat > 0) ? cache_lat : int'($urandom_range(1, 4)));
            pend.push_back(p);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit rw, input logic [19:0] a, input logic [31:0] d,
                        input bit stop);
        @(posedge clk);
        #1;
        req_valid            = v;
        req_rw               = rw;
        req_addr             = a;
        req_data             = d;
        cache_to_cpu.stopped = stop;
        if (pend.size() > 0 && cyc >= pend[0].due) begin
            cache_to_cpu.ready = 1'b1;
            cache_to_cpu.data  = rd_value(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            cache_to_cpu.ready = 1'b0;
            cache_to_cpu.data  = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        check({tag, "_valid"}, 32'(cpu_to_cache.valid), 32'h0);
        check({tag, "_rd_out"}, 32'(rd_outstanding), 32'h0);
        check({tag, "_proto_err"}, 32'(proto_err), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        req_valid    = 1'b0;
        cache_to_cpu = '0;
        pend.delete();
        #1;
        check_reset_state("in_reset");
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("after_reset");
    endtask

    initial begin
        // Power-on reset.
        #2;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-stream: three requests queued behind a stalled cache.
        for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 20'(32'h200 + 4 * i), 32'(i), 1'b1);
        do_reset(2);

        // Fill/full: five writes while stopped, only four fit.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 20'(32'h10 + 4 * i), 32'h5000 + 32'(i), 1'b1);
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("full_req_ready", 32'(req_ready), 32'h0);
        check("full_head_addr", 32'(cpu_to_cache.addr), 32'h10);
        idle(6);

        // In-order reads with fixed cache latency.
        cache_lat = 3;
        step(1'b1, 1'b0, 20'h00004, 32'h0, 1'b0);
        step(1'b1, 1'b0, 20'h00008, 32'h0, 1'b0);
        idle(10);

        // Read-credit stall: R,R,R,W queued, then released with a slow cache.
        cache_lat = 6;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 20'(32'h300 + 4 * i), 32'h0, 1'b1);
        step(1'b1, 1'b1, 20'h0030C, 32'h7777_0000, 1'b1);
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("stall_valid", 32'(cpu_to_cache.valid), 32'h0);
        check("stall_rd_out", 32'(rd_outstanding), 32'(MAX_RD));
        check("stall_head", 32'(cpu_to_cache.addr), 32'h308);
        idle(16);

        // Push and pop together across pointer wrap.
        cache_lat = 0;
        step(1'b1, 1'b1, 20'h00400, 32'hA0, 1'b1);
        step(1'b1, 1'b1, 20'h00404, 32'hA1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 20'(32'h408 + 4 * i), 32'hB0 + 32'(i), 1'b0);
        idle(6);

        // Unsolicited response with nothing outstanding.
        @(posedge clk);
        #1;
        req_valid            = 1'b0;
        cache_to_cpu.stopped = 1'b0;
        cache_to_cpu.ready   = 1'b1;
        cache_to_cpu.data    = 32'hDEADBEEF;
        idle(1);
        @(negedge clk);
        check("perr_flag", 32'(proto_err), 32'h1);
        check("perr_rsp_data", rsp_data, 32'hDEADBEEF);
        check("perr_rd_out", 32'(rd_outstanding), 32'h0);
        idle(3);
        @(negedge clk);
        check("perr_sticky", 32'(proto_err), 32'h1);
        do_reset(2);

        // Randomised traffic.
        repeat (1500) begin
            step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 20'($urandom), $urandom,
                 $urandom_range(0, 9) < 3);
        end

        // Drain and confirm every issued read was answered in order.
        idle(60);
        @(negedge clk);
        check("drain_valid", 32'(cpu_to_cache.valid), 32'h0);
        check("drain_rsp_left", 32'(exp_rsp.size()), 32'h0);
        check("drain_pend_left", 32'(pend.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_req_buffer.md
Name: cpu_req_buffer

Overview:
- In-order request buffer between the CPU/stimulus source and sa_cache.
- Queues CPU read/write requests and issues them to the cache through cpu_to_cache, holding each one while cache_to_cpu.stopped is high.
- Tracks outstanding reads and forwards cache read data back to the CPU in request order.
- Flags any protocol violation, i.e. a ready pulse from the cache with no read outstanding.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- MAX_RD, 4: maximum reads issued to the cache and not yet answered; at least 1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request strobe.
- req_rw  in  1  1 = write, 0 = read (same encoding as cpu_to_cache.rw).
- req_addr  in  20  request address.
- req_data  in  32  write data; ignored for reads.
- req_ready  out  1  buffer can accept a request this cycle.
- cpu_to_cache  out  cpu_to_cache_type  request to sa_cache (data, addr, rw, valid).
- cache_to_cpu  in  cache_to_cpu_type  response from sa_cache (data, ready, stopped).
- rsp_valid  out  1  one-cycle pulse: read data is valid.
- rsp_data  out  32  read data.
- rd_outstanding  out  $clog2(MAX_RD)+1  count of reads issued and not yet answered.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset, async and active-high:
  - FIFO pointers and count go to 0; rd_outstanding = 0.
  - rsp_valid = 0, rsp_data = 0, proto_err = 0.
  - cpu_to_cache is all zeros.
  - Reset in mid-operation discards every queued and outstanding request. Responses that arrive after reset is released count as protocol errors.
- Push:
  - req_ready = (count != DEPTH), combinational from registered state.
  - A request is accepted on a rising edge where req_valid && req_ready.
  - No push-through when full, even if a pop happens in the same cycle.
- Issue:
  - cpu_to_cache.valid = !empty && (head is write || rd_outstanding < MAX_RD).
  - data, addr and rw come from the FIFO head. All fields are 0 when empty.
  - A handshake completes on a rising edge where cpu_to_cache.valid && !cache_to_cpu.stopped. The head is popped on that edge.
  - While stopped = 1 the head is held, all fields stable.
- Simultaneous events:
  - Push and pop on the same edge leave count unchanged. Pointers wrap modulo DEPTH.
  - Push into an empty FIFO becomes visible at the cache the cycle after acceptance (one-cycle minimum latency, req to cache).
- Read tracking:
  - rd_outstanding += 1 on the issue handshake of a read.
  - rd_outstanding -= 1 on a cycle where cache_to_cpu.ready = 1 and rd_outstanding > 0.
  - Both on the same edge leave it unchanged.
  - Writes produce no response and never change rd_outstanding.
  - When rd_outstanding == MAX_RD and the head is a read, issue stalls. A write at the head still issues.
- Response:
  - On each cycle with cache_to_cpu.ready = 1, the next edge sets rsp_valid = 1 and rsp_data = cache_to_cpu.data (one-cycle registered latency).
  - Otherwise rsp_valid = 0 and rsp_data holds its last value.
- Error:
  - cache_to_cpu.ready = 1 with rd_outstanding == 0 sets proto_err, which stays set until reset.
  - The counter does not underflow. rsp_valid still pulses with the data.
- Width rules: count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits.

Decomposition:
- Package cache_definition gains:
  - typedef cpu_req_type {rw, addr[19:0], data[31:0]}, the FIFO entry.
  - constant ADDR_W = 20.
  - constant DATA_W = 32.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty/count, async active-high reset. The buffer instantiates it with the cpu_req_type width. Issue, read-tracking and response logic stay in cpu_req_buffer.

Test Plan:
- Reset mid-stream: push 3 requests, assert rst for 2 cycles -> req_ready=1, cpu_to_cache.valid=0, rd_outstanding=0, proto_err=0 while in reset and after release.
- Fill/full: DEPTH=4, stopped=1, push 5 writes back-to-back -> 4 accepted, req_ready=0 on the 5th, cpu_to_cache holds the entry-0 addr 0x00010 stable while stopped.
- In-order reads: reads to 0x00004, 0x00008 with a cache model returning 0xAAAA0004, 0xBBBB0008 after 3 cycles -> rsp_valid pulses twice, in that order, each one cycle after ready; rd_outstanding goes 0,1,2,1,0.
- MAX_RD stall: MAX_RD=2, queue R,R,R,W, no ready -> two reads issue, then valid=0 with the third read at the head; one ready pulse -> third read issues the next cycle.
- Push and pop together: FIFO holds 2 entries, stopped=0, req_valid=1 for 6 cycles -> count stays 2, addresses issue in exact push order across pointer wrap.
- Protocol error: with nothing outstanding, drive ready=1 with data 0xDEADBEEF -> proto_err=1 stays set, rd_outstanding stays 0, rsp_data=0xDEADBEEF.
